// File: rtl/spi_drv_arbiter.sv
// Round-robin arbiter sharing one SPI_Master (CPOL=0, CPHA=1) among NUM_DEV slaves.
// Sequences START/DATA_IN, gates SEL onto per-device chip selects, returns the word.
module spi_drv_arbiter #(
  parameter int unsigned NUM_DEV        = 5,
  parameter int unsigned DATA_WIDTH     = 16,
  parameter int unsigned GAP_CYCLES     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  localparam int unsigned DevW          = (NUM_DEV > 1) ? $clog2(NUM_DEV) : 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_DEV-1:0]           req,
  input  logic [NUM_DEV*DATA_WIDTH-1:0] req_data,
  output logic [NUM_DEV-1:0]           ack,
  output logic [DATA_WIDTH-1:0]        resp_data,
  output logic                         resp_err,
  output logic                         spi_start,
  output logic [DATA_WIDTH-1:0]        spi_data_in,
  input  logic                         spi_busy,
  input  logic                         spi_valid,
  input  logic [DATA_WIDTH-1:0]        spi_data_out,
  input  logic                         spi_sel,
  output logic [NUM_DEV-1:0]           dev_ncs,
  output logic [DevW-1:0]              active_dev
);

  localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned GapW = $clog2(GAP_CYCLES + 1);

  localparam logic [2:0] StIdle     = 3'd0;
  localparam logic [2:0] StLaunch   = 3'd1;
  localparam logic [2:0] StWaitBusy = 3'd2;
  localparam logic [2:0] StXfer     = 3'd3;
  localparam logic [2:0] StDone     = 3'd4;
  localparam logic [2:0] StGap      = 3'd5;

  logic [2:0]            state_q, state_d;
  logic [DevW-1:0]       last_grant_q, active_dev_q, grant_idx;
  logic                  grant_found;
  logic [TmoW-1:0]       tmo_cnt_q;
  logic [GapW-1:0]       gap_cnt_q;
  logic [DATA_WIDTH-1:0] spi_data_q, rx_q, resp_data_q;
  logic                  rx_seen_q, err_q, resp_err_q;
  logic [NUM_DEV-1:0]    ack_q;
  logic                  timeout;

  assign timeout = (tmo_cnt_q == TmoW'(TIMEOUT_CYCLES));

  // First requesting device strictly after last_grant, wrapping around.
  always_comb begin
    int unsigned     cand;
    logic [DevW-1:0] cand_idx;
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = 0;
    cand_idx    = '0;
    for (int unsigned k = 1; k <= NUM_DEV; k++) begin
      cand     = (32'(last_grant_q) + k) % NUM_DEV;
      cand_idx = DevW'(cand);
      if (!grant_found && req[cand_idx]) begin
        grant_found = 1'b1;
        grant_idx   = cand_idx;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:     if (grant_found) state_d = StLaunch;
      StLaunch:   state_d = StWaitBusy;
      StWaitBusy: begin
        if (timeout)       state_d = StDone;
        else if (spi_busy) state_d = StXfer;
      end
      StXfer: begin
        if (timeout || !spi_busy) state_d = StDone;
      end
      StDone:     state_d = StGap;
      StGap:      if (gap_cnt_q == GapW'(GAP_CYCLES - 1)) state_d = StIdle;
      default:    state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      last_grant_q <= DevW'(NUM_DEV - 1);
      active_dev_q <= '0;
      tmo_cnt_q    <= '0;
      gap_cnt_q    <= '0;
      spi_data_q   <= '0;
      rx_q         <= '0;
      rx_seen_q    <= 1'b0;
      err_q        <= 1'b0;
      resp_data_q  <= '0;
      resp_err_q   <= 1'b0;
      ack_q        <= '0;
    end else begin
      state_q <= state_d;
      ack_q   <= '0;
      case (state_q)
        StIdle: begin
          if (grant_found) begin
            active_dev_q <= grant_idx;
            last_grant_q <= grant_idx;
            spi_data_q   <= req_data[32'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];
          end
        end
        StLaunch: begin
          tmo_cnt_q <= '0;
          rx_seen_q <= 1'b0;
          err_q     <= 1'b0;
        end
        StWaitBusy, StXfer: begin
          if (timeout) begin
            err_q <= 1'b1;
            rx_q  <= '0;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
            // Without a VALID strobe, whatever DATA_OUT shows as BUSY falls is returned.
            if (state_q == StXfer && (spi_valid || (!spi_busy && !rx_seen_q))) begin
              rx_q <= spi_data_out;
            end
            if (state_q == StXfer && spi_valid) rx_seen_q <= 1'b1;
          end
        end
        StDone: begin
          ack_q       <= NUM_DEV'(1) << active_dev_q;
          resp_data_q <= rx_q;
          resp_err_q  <= err_q;
          gap_cnt_q   <= '0;
        end
        StGap: gap_cnt_q <= gap_cnt_q + 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < NUM_DEV; i++) begin
      dev_ncs[i] = ~(spi_sel && (active_dev_q == DevW'(i)) &&
                     (state_q == StWaitBusy || state_q == StXfer));
    end
  end

  assign spi_start   = (state_q == StLaunch);
  assign spi_data_in = spi_data_q;
  assign ack         = ack_q;
  assign resp_data   = resp_data_q;
  assign resp_err    = resp_err_q;
  assign active_dev  = active_dev_q;

endmodule

// File: tb/tb_spi_drv_arbiter.sv
// Bench for spi_drv_arbiter: behavioural SPI_Master stand-in plus a round-robin
// reference model; directed scenarios followed by randomized request sets.
module tb_spi_drv_arbiter;
  localparam int N   = 5;
  localparam int W   = 16;
  localparam int GAP = 4;
  localparam int TMO = 1024;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   req = '0;
  logic [N*W-1:0] req_data = '0;
  logic [N-1:0]   ack;
  logic [W-1:0]   resp_data;
  logic           resp_err;
  logic           spi_start;
  logic [W-1:0]   spi_data_in;
  logic           spi_busy = 1'b0;
  logic           spi_valid = 1'b0;
  logic [W-1:0]   spi_data_out = '0;
  logic           spi_sel = 1'b0;
  logic [N-1:0]   dev_ncs;
  logic [2:0]     active_dev;

  spi_drv_arbiter #(
    .NUM_DEV(N), .DATA_WIDTH(W), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_data(req_data), .ack(ack),
    .resp_data(resp_data), .resp_err(resp_err), .spi_start(spi_start),
    .spi_data_in(spi_data_in), .spi_busy(spi_busy), .spi_valid(spi_valid),
    .spi_data_out(spi_data_out), .spi_sel(spi_sel), .dev_ncs(dev_ncs),
    .active_dev(active_dev)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          errors = 0;
  int          checks = 0;
  int          last = N - 1;
  int unsigned ack_cyc = 0;
  bit          gap_chk = 1'b0;
  logic [N-1:0] all_hi = '1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("check %s differs", tag);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int pick(input logic [N-1:0] m, input int lst);
    for (int k = 1; k <= N; k++) begin
      if (m[(lst + k) % N]) return (lst + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [W-1:0] slice(input int d);
    return req_data[d*W +: W];
  endfunction

  task automatic do_reset();
    spi_busy = 1'b0; spi_sel = 1'b0; spi_valid = 1'b0;
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    last = N - 1;
    gap_chk = 1'b0;
  endtask

  // mode 0: VALID strobe, 1: no VALID (word taken at BUSY fall), 2: BUSY never rises
  task automatic serve(input int dev, input int mode, input logic [W-1:0] miso,
                       input bit drop_early, input bit hold, input logic [N-1:0] raise);
    int           n;
    int           len;
    int           vpos;
    bit           ncs_bad;
    logic [N-1:0] onehot;
    logic [W-1:0] exp_resp;
    bit           err;
    onehot = '0;
    onehot[dev] = 1'b1;
    n = 0;
    ncs_bad = 1'b0;
    while (spi_start !== 1'b1 && n < 40) begin
      if (dev_ncs !== all_hi) ncs_bad = 1'b1;
      tick();
      n++;
    end
    check("start_seen", {31'd0, spi_start}, 1);
    if (spi_start !== 1'b1) return;
    if (gap_chk) begin
      check("gap_len", {31'd0, (cyc - ack_cyc) >= GAP}, 1);
      check("gap_ncs", {31'd0, ncs_bad}, 0);
    end
    check("grant", {29'd0, active_dev}, dev);
    check("mosi", {16'd0, spi_data_in}, {16'd0, slice(dev)});
    if (drop_early) req[dev] = 1'b0;
    req = req | raise;
    tick();
    check("start_pulse", {31'd0, spi_start}, 0);
    if (mode == 2) begin
      n = 1;
      ncs_bad = 1'b0;
      while (ack === '0 && n < TMO + 20) begin
        if (dev_ncs !== all_hi) ncs_bad = 1'b1;
        tick();
        n++;
      end
      check("tmo_latency", n, TMO + 3);
      check("tmo_ncs", {31'd0, ncs_bad}, 0);
      exp_resp = '0;
      err = 1'b1;
    end else begin
      repeat ($urandom_range(0, 3)) tick();
      spi_busy = 1'b1; spi_sel = 1'b1;
      #1 check("ncs_sel", {27'd0, dev_ncs}, {27'd0, ~onehot});
      len = $urandom_range(2, 6);
      vpos = $urandom_range(0, len - 1);
      for (int i = 0; i < len; i++) begin
        tick();
        spi_valid = (mode == 0 && i == vpos);
        spi_data_out = spi_valid ? miso : W'($urandom);
        #1 check("ncs_xfer", {27'd0, dev_ncs}, {27'd0, ~onehot});
      end
      tick();
      spi_busy = 1'b0; spi_sel = 1'b0; spi_valid = 1'b0;
      spi_data_out = (mode == 1) ? miso : W'($urandom);
      #1 check("ncs_release", {27'd0, dev_ncs}, {27'd0, all_hi});
      tick();
      spi_data_out = W'($urandom);
      n = 0;
      while (ack === '0 && n < 20) begin
        tick();
        n++;
      end
      exp_resp = miso;
      err = 1'b0;
    end
    check("ack", {27'd0, ack}, {27'd0, onehot});
    check("resp_data", {16'd0, resp_data}, {16'd0, exp_resp});
    check("resp_err", {31'd0, resp_err}, {31'd0, err});
    ack_cyc = cyc;
    gap_chk = 1'b1;
    last = dev;
    if (!hold) req[dev] = 1'b0;
    tick();
    check("ack_pulse", {27'd0, ack}, 0);
    check("resp_hold", {16'd0, resp_data}, {16'd0, exp_resp});
  endtask

  initial begin
    int           exp_dev;
    int           n;
    bit           ack_seen;
    logic [N-1:0] m;

    // Reset values, observed while reset is still asserted.
    #2;
    check("rst_ack", {27'd0, ack}, 0);
    check("rst_resp", {16'd0, resp_data}, 0);
    check("rst_err", {31'd0, resp_err}, 0);
    check("rst_start", {31'd0, spi_start}, 0);
    check("rst_mosi", {16'd0, spi_data_in}, 0);
    check("rst_active", {29'd0, active_dev}, 0);
    check("rst_ncs", {27'd0, dev_ncs}, {27'd0, all_hi});
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // Single transfer on device 2.
    req_data[2*W +: W] = 16'hd10d;
    req = 5'b00100;
    serve(pick(req, last), 0, 16'h1234, 1'b0, 1'b0, '0);

    // All devices at once from reset: round-robin starting at 0.
    do_reset();
    for (int d = 0; d < N; d++) req_data[d*W +: W] = W'($urandom);
    req = '1;
    while (req != '0) begin
      exp_dev = pick(req, last);
      serve(exp_dev, $urandom_range(0, 1), W'($urandom), 1'b0, 1'b0, '0);
    end

    // Device 0 held high; device 3 raised during the device-0 transfer.
    req = 5'b00001;
    serve(pick(req, last), 0, W'($urandom), 1'b0, 1'b1, 5'b01000);
    serve(pick(req, last), 0, W'($urandom), 1'b0, 1'b0, '0);
    serve(pick(req, last), 0, W'($urandom), 1'b0, 1'b0, '0);

    // Timeout with BUSY stuck low.
    req = 5'b00010;
    serve(pick(req, last), 2, W'($urandom), 1'b0, 1'b0, '0);

    // Reset asserted in the middle of a transfer.
    req = 5'b10000;
    n = 0;
    while (spi_start !== 1'b1 && n < 40) begin tick(); n++; end
    tick();
    spi_busy = 1'b1; spi_sel = 1'b1;
    tick(); tick();
    rst_n = 1'b0;
    #1;
    check("arst_ncs", {27'd0, dev_ncs}, {27'd0, all_hi});
    check("arst_start", {31'd0, spi_start}, 0);
    check("arst_ack", {27'd0, ack}, 0);
    check("arst_active", {29'd0, active_dev}, 0);
    spi_busy = 1'b0; spi_sel = 1'b0;
    req = '0;
    tick(); tick();
    rst_n = 1'b1;
    last = N - 1;
    gap_chk = 1'b0;
    ack_seen = 1'b0;
    repeat (10) begin
      if (ack !== '0) ack_seen = 1'b1;
      tick();
    end
    check("arst_no_ack", {31'd0, ack_seen}, 0);
    req = 5'b01000;
    serve(pick(req, last), 0, W'($urandom), 1'b0, 1'b0, '0);
    do_reset();
    req = '1;
    serve(pick(req, last), 1, W'($urandom), 1'b0, 1'b0, '0);
    req = '0;

    // Randomized request sets, some dropped right after grant.
    for (int r = 0; r < 6; r++) begin
      m = N'($urandom_range(1, (1 << N) - 1));
      for (int d = 0; d < N; d++) req_data[d*W +: W] = W'($urandom);
      req = m;
      while (req != '0) begin
        exp_dev = pick(req, last);
        serve(exp_dev, $urandom_range(0, 1), W'($urandom), bit'($urandom_range(0, 1)),
              1'b0, '0);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
